// File: rtl/axis_detector_trigger_pkg.sv
// Purpose: shared FSM state encoding and derived-width helper for the coincidence trigger.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package axis_detector_trigger_pkg;

    // Event lifecycle: detect, widen the hit window, reduce to groups,
    // count groups, decide, hand off downstream, then enforce dead time.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCUM   = 3'd1,
        ST_GROUP   = 3'd2,
        ST_SUM     = 3'd3,
        ST_DECIDE  = 3'd4,
        ST_SEND    = 3'd5,
        ST_HOLDOFF = 3'd6
    } state_t;

    // Bits needed to hold a group count from 0 to group_count inclusive.
    function automatic int sum_width(input int group_count);
        return $clog2(group_count + 1);
    endfunction

endpackage

// File: rtl/axis_detector_trigger_if.sv
// Purpose: AXI4-Stream style event channel (valid/ready plus data).
// Latency: n/a (wires only).
// Backpressure: producer holds tvalid/tdata until tready is seen high.
//
// Signals: tvalid (master->slave), tready (slave->master), tdata (master->slave).
interface axis_detector_trigger_if #(
    parameter int TDATA_WIDTH = 128
) ();

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );

endinterface

// File: rtl/axis_detector_trigger_det_group_reduce.sv
// Purpose: combinational per-group OR of the hit mask and popcount of the group vector.
// Latency: 0 cycles (pure combinational; the caller registers both results).
// Backpressure: none.
//
// Ports: mask       - accumulated hit mask, DET_WIDTH bits
//        gor_in     - registered group activity to be counted
//        gor        - per-group OR of mask, one bit per group
//        sum        - number of set bits in gor_in
// DET_WIDTH must be an integer multiple of GROUP_COUNT; groups are equal
// contiguous slices with group 0 in the least significant bits.
module det_group_reduce
    import axis_detector_trigger_pkg::*;
#(
    parameter int  DET_WIDTH   = 64,
    parameter int  GROUP_COUNT = 4,
    localparam int SUM_WIDTH   = sum_width(GROUP_COUNT)
) (
    input  logic [DET_WIDTH-1:0]   mask,
    input  logic [GROUP_COUNT-1:0] gor_in,
    output logic [GROUP_COUNT-1:0] gor,
    output logic [SUM_WIDTH-1:0]   sum
);

    localparam int GROUP_BITS = DET_WIDTH / GROUP_COUNT;

    always_comb begin
        gor = '0;
        for (int g = 0; g < GROUP_COUNT; g++) begin
            gor[g] = |mask[g*GROUP_BITS +: GROUP_BITS];
        end
    end

    // SUM_WIDTH holds GROUP_COUNT exactly, so the running total cannot wrap.
    always_comb begin
        sum = '0;
        for (int g = 0; g < GROUP_COUNT; g++) begin
            sum = sum + SUM_WIDTH'(gor_in[g]);
        end
    end

endmodule

// File: rtl/axis_detector_trigger.sv
// Purpose: coincidence trigger - ORs hits over a window, counts active groups, emits {timestamp, mask}.
// Latency: first tvalid W+4 cycles after the detection cycle (the IDLE cycle whose d0 has a hit).
// Backpressure: the beat is held stable in SEND until tready; hits arriving meanwhile are only counted.
//
// Ports: aclk, aresetn       - single rising-edge clock, synchronous active-low reset
//        det_data            - raw hit bus, registered every cycle into d0
//        cfg_enable          - allows leaving IDLE; an event already started always completes
//        cfg_window          - extra accumulation cycles W (mask spans W+1 samples)
//        cfg_thresh          - minimum number of active groups to accept an event
//        cfg_holdoff         - dead time H; HOLDOFF lasts H+1 cycles
//        m_axis              - event stream master, tdata = {timestamp, hit mask}
//        sts_accepted        - events that met the threshold
//        sts_rejected        - events that fell short of the threshold
//        sts_busy_hits       - cycles with a hit seen while the trigger could not start an event
module axis_detector_trigger
    import axis_detector_trigger_pkg::*;
#(
    parameter int  DET_WIDTH   = 64,
    parameter int  GROUP_COUNT = 4,
    parameter int  TIME_WIDTH  = 64,
    parameter int  CNTR_WIDTH  = 8,
    localparam int SUM_WIDTH   = sum_width(GROUP_COUNT)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [DET_WIDTH-1:0]    det_data,
    input  logic                    cfg_enable,
    input  logic [CNTR_WIDTH-1:0]   cfg_window,
    input  logic [SUM_WIDTH-1:0]    cfg_thresh,
    input  logic [CNTR_WIDTH-1:0]   cfg_holdoff,
    axis_detector_trigger_if.master m_axis,
    output logic [31:0]             sts_accepted,
    output logic [31:0]             sts_rejected,
    output logic [31:0]             sts_busy_hits
);

    typedef struct packed {
        logic [TIME_WIDTH-1:0] ts;
        logic [DET_WIDTH-1:0]  mask;
    } event_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [DET_WIDTH-1:0]   d0_q;
    logic [TIME_WIDTH-1:0]  t_q;
    event_t                 ev_q;
    logic [CNTR_WIDTH-1:0]  cntr_q;
    logic [GROUP_COUNT-1:0] gor_q;
    logic [SUM_WIDTH-1:0]   sum_q;
    logic                   tvalid_q;
    logic [31:0]            acc_q;
    logic [31:0]            rej_q;
    logic [31:0]            busy_q;

    logic [GROUP_COUNT-1:0] gor_c;
    logic [SUM_WIDTH-1:0]   sum_c;

    logic hit;
    logic start;
    logic accum;
    logic accept;
    logic reject;
    logic handshake;
    logic cntr_clr;
    logic cntr_inc;
    logic busy_cycle;

    assign hit = |d0_q;

    det_group_reduce #(
        .DET_WIDTH   (DET_WIDTH),
        .GROUP_COUNT (GROUP_COUNT)
    ) u_reduce (
        .mask   (ev_q.mask),
        .gor_in (gor_q),
        .gor    (gor_c),
        .sum    (sum_c)
    );

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        accum     = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        handshake = 1'b0;
        cntr_clr  = 1'b0;
        cntr_inc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_enable && hit) begin
                    start   = 1'b1;
                    state_d = (cfg_window == '0) ? ST_GROUP : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // Counter starts at 1 on detection, so W ACCUM cycles
                // plus the detection sample give W+1 samples in the mask.
                accum = 1'b1;
                if (cntr_q == cfg_window) begin
                    state_d = ST_GROUP;
                end else begin
                    cntr_inc = 1'b1;
                end
            end
            ST_GROUP: begin
                state_d = ST_SUM;
            end
            ST_SUM: begin
                state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (sum_q >= cfg_thresh) begin
                    accept  = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    reject   = 1'b1;
                    cntr_clr = 1'b1;
                    state_d  = ST_HOLDOFF;
                end
            end
            ST_SEND: begin
                if (m_axis.tready) begin
                    handshake = 1'b1;
                    cntr_clr  = 1'b1;
                    state_d   = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (cntr_q == cfg_holdoff) begin
                    state_d = ST_IDLE;
                end else begin
                    cntr_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Hits the trigger cannot act on: anywhere past the accumulation window
    // until IDLE is re-entered, including the last HOLDOFF cycle.
    assign busy_cycle = hit && (state_q != ST_IDLE) && (state_q != ST_ACCUM);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            d0_q     <= '0;
            t_q      <= '0;
            ev_q     <= '0;
            cntr_q   <= '0;
            gor_q    <= '0;
            sum_q    <= '0;
            tvalid_q <= 1'b0;
            acc_q    <= '0;
            rej_q    <= '0;
            busy_q   <= '0;
        end else begin
            state_q <= state_d;
            d0_q    <= det_data;
            t_q     <= t_q + 1'b1;

            if (start) begin
                ev_q.ts   <= t_q;
                ev_q.mask <= d0_q;
            end else if (accum) begin
                ev_q.mask <= ev_q.mask | d0_q;
            end

            if (start) begin
                cntr_q <= CNTR_WIDTH'(1);
            end else if (cntr_clr) begin
                cntr_q <= '0;
            end else if (cntr_inc) begin
                cntr_q <= cntr_q + 1'b1;
            end

            if (state_q == ST_GROUP) begin
                gor_q <= gor_c;
            end
            if (state_q == ST_SUM) begin
                sum_q <= sum_c;
            end

            if (accept) begin
                tvalid_q <= 1'b1;
            end else if (handshake) begin
                tvalid_q <= 1'b0;
            end

            if (accept) begin
                acc_q <= acc_q + 32'd1;
            end
            if (reject) begin
                rej_q <= rej_q + 32'd1;
            end
            if (busy_cycle) begin
                busy_q <= busy_q + 32'd1;
            end
        end
    end

    // ts and mask are frozen from DECIDE until the handshake, so the beat
    // is taken straight from the event record without a separate copy.
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = ev_q;

    assign sts_accepted  = acc_q;
    assign sts_rejected  = rej_q;
    assign sts_busy_hits = busy_q;

endmodule

// File: tb/tb_axis_detector_trigger.sv
// Purpose: directed bench for axis_detector_trigger with a cycle-level event model.
// Latency: n/a.
// Backpressure: tready driven from the stimulus process.
module tb_axis_detector_trigger;

    localparam int DW = 64;
    localparam int GC = 4;
    localparam int TW = 64;
    localparam int CW = 8;
    localparam int SW = $clog2(GC + 1);
    localparam int GW = DW / GC;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] det_data;
    logic          cfg_enable;
    logic [CW-1:0] cfg_window;
    logic [SW-1:0] cfg_thresh;
    logic [CW-1:0] cfg_holdoff;
    logic [31:0]   sts_accepted;
    logic [31:0]   sts_rejected;
    logic [31:0]   sts_busy_hits;

    axis_detector_trigger_if #(.TDATA_WIDTH(TW + DW)) axis ();

    axis_detector_trigger #(
        .DET_WIDTH   (DW),
        .GROUP_COUNT (GC),
        .TIME_WIDTH  (TW),
        .CNTR_WIDTH  (CW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .det_data      (det_data),
        .cfg_enable    (cfg_enable),
        .cfg_window    (cfg_window),
        .cfg_thresh    (cfg_thresh),
        .cfg_holdoff   (cfg_holdoff),
        .m_axis        (axis),
        .sts_accepted  (sts_accepted),
        .sts_rejected  (sts_rejected),
        .sts_busy_hits (sts_busy_hits)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Model state, expressed as event timing rather than FSM states.
    int               cyc = 0;
    int               rst_cyc = 0;
    bit               m_live = 1'b0;
    bit               m_in_rst = 1'b0;
    bit               m_ev = 1'b0;
    bit               m_vld = 1'b0;
    int               m_c = 0;
    int               m_free = 0;
    logic [TW-1:0]    m_t = '0;
    logic [TW-1:0]    m_ts = '0;
    logic [DW-1:0]    m_d0 = '0;
    logic [DW-1:0]    m_mask = '0;
    logic [31:0]      m_acc = '0;
    logic [31:0]      m_rej = '0;
    logic [31:0]      m_busy = '0;
    bit               obs_vld = 1'b0;
    bit               prev_vld = 1'b0;
    logic [TW+DW-1:0] obs_dat = '0;

    logic [DW-1:0] beat_mask[$];
    logic [TW-1:0] beat_ts[$];
    int            hs_cyc[$];
    int            first_vld[$];

    initial begin : model
        bit            rst_s, en_s, rdy_s, post;
        logic [DW-1:0] det_s;
        logic [CW-1:0] w_s, h_s;
        logic [SW-1:0] th_s;
        int            groups;
        forever begin
            @(posedge aclk);
            rst_s = !aresetn;
            en_s  = cfg_enable;
            rdy_s = axis.tready;
            det_s = det_data;
            w_s   = cfg_window;
            h_s   = cfg_holdoff;
            th_s  = cfg_thresh;

            if (m_live && !rst_s && obs_vld && rdy_s) begin
                beat_mask.push_back(obs_dat[DW-1:0]);
                beat_ts.push_back(obs_dat[DW +: TW]);
                hs_cyc.push_back(cyc);
            end

            if (rst_s) begin
                m_live = 1'b1; m_in_rst = 1'b1;
                m_t = '0; m_ts = '0; m_d0 = '0; m_mask = '0;
                m_ev = 1'b0; m_vld = 1'b0; m_free = 0;
                m_acc = '0; m_rej = '0; m_busy = '0;
                rst_cyc = cyc + 1;
            end else if (m_live) begin
                m_in_rst = 1'b0;
                post = m_ev ? (cyc > m_c + int'(w_s)) : (cyc < m_free);
                if ((|m_d0) && post) m_busy = m_busy + 1;
                if (!m_ev) begin
                    if (cyc >= m_free && en_s && (|m_d0)) begin
                        m_ev = 1'b1; m_c = cyc; m_ts = m_t; m_mask = m_d0;
                    end
                end else if (m_vld) begin
                    if (rdy_s) begin
                        m_vld = 1'b0; m_ev = 1'b0; m_free = cyc + int'(h_s) + 2;
                    end
                end else begin
                    if (cyc <= m_c + int'(w_s)) m_mask = m_mask | m_d0;
                    if (cyc == m_c + int'(w_s) + 3) begin
                        groups = 0;
                        for (int g = 0; g < GC; g++)
                            if (m_mask[g*GW +: GW] != '0) groups++;
                        if (groups >= int'(th_s)) begin
                            m_acc = m_acc + 1; m_vld = 1'b1;
                        end else begin
                            m_rej = m_rej + 1; m_ev = 1'b0; m_free = cyc + int'(h_s) + 2;
                        end
                    end
                end
                m_t  = m_t + 1;
                m_d0 = det_s;
            end
            cyc++;

            #2;
            if (m_live) begin
                check("tvalid", axis.tvalid, m_vld);
                check("sts_accepted", sts_accepted, m_acc);
                check("sts_rejected", sts_rejected, m_rej);
                check("sts_busy_hits", sts_busy_hits, m_busy);
                if (m_vld) check("tdata", axis.tdata, {m_ts, m_mask});
                if (m_in_rst) check("reset_tdata", axis.tdata, '0);
                if (axis.tvalid && !prev_vld) first_vld.push_back(cyc);
                prev_vld = axis.tvalid;
                obs_vld  = axis.tvalid;
                obs_dat  = axis.tdata;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge aclk);
    endtask

    task automatic pulse(input logic [DW-1:0] v);
        det_data = v;
        tick();
        det_data = '0;
    endtask

    initial begin : stim
        int c, nb, nf, nh, guard;

        aresetn = 1'b0; det_data = '0; cfg_enable = 1'b1;
        cfg_window = '0; cfg_holdoff = '0; cfg_thresh = 3'd2; axis.tready = 1'b1;
        tick(3);
        check("reset_tvalid", axis.tvalid, 0);
        check("reset_acc", sts_accepted, 0);
        aresetn = 1'b1;
        tick(2);

        // Single two-group hit, W=0.
        nb = beat_mask.size(); nf = first_vld.size();
        c = cyc + 1;
        pulse(64'h0001_0000_0000_0001);
        tick(10);
        check("s1_beats", beat_mask.size() - nb, 1);
        if (beat_mask.size() > nb) begin
            check("s1_mask", beat_mask[nb], 64'h0001_0000_0000_0001);
            check("s1_ts", beat_ts[nb], c - rst_cyc);
        end
        if (first_vld.size() > nf) check("s1_latency", first_vld[nf] - c, 4);
        check("s1_acc", sts_accepted, 1);

        // Window W=3, late hit after the window excluded.
        cfg_enable = 1'b0; cfg_window = 8'd3; cfg_thresh = 3'd3; cfg_enable = 1'b1;
        nb = beat_mask.size(); nf = first_vld.size();
        c = cyc + 1;
        det_data = 64'd1;        tick();
        det_data = '0;           tick();
        det_data = 64'd1 << 20;  tick();
        det_data = 64'd1 << 40;  tick();
        det_data = '0;           tick();
        det_data = 64'd1 << 60;  tick();
        det_data = '0;
        tick(15);
        check("s2_beats", beat_mask.size() - nb, 1);
        if (beat_mask.size() > nb) check("s2_mask", beat_mask[nb], 64'h0000_0100_0010_0001);
        if (first_vld.size() > nf) check("s2_latency", first_vld[nf] - c, 7);
        check("s2_acc", sts_accepted, 2);
        check("s2_busy", sts_busy_hits, 1);

        // Threshold boundaries.
        cfg_window = '0; cfg_thresh = 3'd3;
        nb = beat_mask.size();
        pulse(64'hFFFF); tick(10);
        check("s3_rej", sts_rejected, 1);
        check("s3_no_beat", beat_mask.size() - nb, 0);
        cfg_thresh = 3'd0;
        pulse(64'hFFFF); tick(10);
        check("s3_thresh0_beat", beat_mask.size() - nb, 1);
        cfg_thresh = 3'd4;
        pulse('1); tick(10);
        check("s3_thresh4_acc", sts_accepted, 4);
        cfg_thresh = 3'd5;
        pulse('1); tick(10);
        check("s3_thresh5_rej", sts_rejected, 2);

        // Backpressure: 10 stalled SEND cycles each with a hit.
        cfg_holdoff = 8'd2; cfg_thresh = 3'd1;
        nb = beat_mask.size(); nf = first_vld.size(); nh = hs_cyc.size();
        c = cyc + 1;
        for (int i = 0; i < 16; i++) begin
            det_data    = (i == 0) ? 64'd1 : ((i >= 4 && i <= 13) ? (64'd1 << (i * 4)) : 64'd0);
            axis.tready = !(i >= 5 && i <= 14);
            tick();
        end
        check("s4_busy", sts_busy_hits, 11);
        check("s4_beats", beat_mask.size() - nb, 1);
        if (beat_mask.size() > nb) check("s4_mask", beat_mask[nb], 64'd1);
        if (hs_cyc.size() > nh) check("s4_hs_cycle", hs_cyc[nh] - c, 14);
        det_data = 64'h8000_0000_0000_0000;
        tick(12);
        det_data = '0;
        if (first_vld.size() > nf + 1 && hs_cyc.size() > nh)
            check("s4_next_event", first_vld[nf + 1] - hs_cyc[nh], 8);
        else
            check("s4_next_event_seen", first_vld.size() - nf, 2);
        tick(15);

        // Continuous hits with H=5, then disable with an event in flight.
        cfg_enable = 1'b0; cfg_holdoff = 8'd5; tick(); cfg_enable = 1'b1;
        nf = first_vld.size();
        det_data = 64'h0000_0000_0001_0000;
        tick(40);
        check("s5_event_count", (first_vld.size() - nf) >= 3, 1);
        for (int i = nf; i + 1 < first_vld.size(); i++)
            check("s5_spacing", first_vld[i + 1] - first_vld[i], 11);
        guard = 0;
        while (!axis.tvalid && guard < 30) begin tick(); guard++; end
        check("s5_wait_tvalid", axis.tvalid, 1);
        tick(9);
        cfg_enable = 1'b0;
        nb = beat_mask.size();
        tick(30);
        check("s5_inflight_delivered", beat_mask.size() - nb, 1);
        det_data = '0;
        tick(5);

        // Reset during ACCUM.
        cfg_window = 8'd3; cfg_holdoff = '0; cfg_thresh = 3'd1; cfg_enable = 1'b1;
        pulse(64'd1);
        tick();
        aresetn = 1'b0;
        tick();
        check("s6a_tvalid", axis.tvalid, 0);
        check("s6a_tdata", axis.tdata, '0);
        check("s6a_acc", sts_accepted, 0);
        check("s6a_rej", sts_rejected, 0);
        check("s6a_busy", sts_busy_hits, 0);
        aresetn = 1'b1;
        cfg_window = '0; cfg_thresh = 3'd2;
        tick(3);
        nb = beat_mask.size(); nf = first_vld.size();
        c = cyc + 1;
        pulse(64'h0001_0000_0000_0001);
        tick(10);
        check("s6a_beats", beat_mask.size() - nb, 1);
        if (beat_mask.size() > nb) begin
            check("s6a_mask", beat_mask[nb], 64'h0001_0000_0000_0001);
            check("s6a_ts", beat_ts[nb], c - rst_cyc);
        end
        if (first_vld.size() > nf) check("s6a_latency", first_vld[nf] - c, 4);
        check("s6a_acc_after", sts_accepted, 1);

        // Reset during SEND.
        axis.tready = 1'b0; cfg_thresh = 3'd1;
        pulse(64'd1);
        guard = 0;
        while (!axis.tvalid && guard < 20) begin tick(); guard++; end
        check("s6b_wait_tvalid", axis.tvalid, 1);
        tick(2);
        aresetn = 1'b0;
        tick();
        check("s6b_tvalid", axis.tvalid, 0);
        check("s6b_tdata", axis.tdata, '0);
        check("s6b_acc", sts_accepted, 0);
        aresetn = 1'b1;
        axis.tready = 1'b1;
        tick(8);
        check("s6b_no_replay", axis.tvalid, 0);
        check("s6b_acc_after", sts_accepted, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_detector_trigger.md
# axis_detector_trigger

Parametrised coincidence trigger for segmented detector front ends. It samples a wide hit bus and ORs hits over a programmable window. It reduces the result to per-group activity, counts active groups against a threshold, and emits timestamped events on an AXI4-Stream master. New capabilities: runtime window, holdoff, enable and status counters.

## Interface
- DET_WIDTH, 64, hit bus width; must be a multiple of GROUP_COUNT
- GROUP_COUNT, 4, number of detector groups; group g = bits [(g+1)*DET_WIDTH/GROUP_COUNT-1 : g*DET_WIDTH/GROUP_COUNT]
- TIME_WIDTH, 64, timestamp counter width
- CNTR_WIDTH, 8, width of window/holdoff counters
- SUM_WIDTH (derived), $clog2(GROUP_COUNT+1)
- aclk  in  1  single clock; all logic on rising edge
- aresetn  in  1  synchronous, active-low reset
- det_data  in  DET_WIDTH  raw hit bits, sampled every cycle
- cfg_enable  in  1  arms trigger from IDLE
- cfg_window  in  CNTR_WIDTH  extra accumulation cycles W
- cfg_thresh  in  SUM_WIDTH  minimum active groups
- cfg_holdoff  in  CNTR_WIDTH  dead time H after each event
- m_axis_tready  in  1  downstream ready
- m_axis_tvalid  out  1  event valid
- m_axis_tdata  out  TIME_WIDTH+DET_WIDTH  {timestamp, hit mask}
- sts_accepted  out  32  events passing threshold
- sts_rejected  out  32  events below threshold
- sts_busy_hits  out  32  cycles with hits while not in IDLE/ACCUM

## Operation
- Input register d0 <= det_data every cycle. Free-running T increments every cycle and wraps modulo 2^TIME_WIDTH.
- IDLE: if cfg_enable and |d0: ts <= T, mask <= d0, cntr <= 1; next ACCUM if W>0, else GROUP. cfg_enable=0 blocks only the IDLE exit; an event in progress completes.
- ACCUM: mask <= mask | d0. If cntr==W go GROUP, else cntr++. The mask covers W+1 consecutive d0 samples.
- GROUP: gor[g] <= |mask[group g]; go SUM.
- SUM: sum <= popcount(gor), SUM_WIDTH bits, no overflow by construction; go DECIDE.
- DECIDE: if sum >= cfg_thresh: tvalid <= 1, sts_accepted++, go SEND. Else sts_rejected++, cntr <= 0, go HOLDOFF. cfg_thresh=0 accepts every event. cfg_thresh>GROUP_COUNT rejects every event.
- SEND: hold tdata/tvalid stable. On tvalid&&tready: tvalid <= 0, cntr <= 0, go HOLDOFF.
- HOLDOFF: if cntr==H go IDLE, else cntr++. The state lasts H+1 cycles.
- sts_busy_hits increments in any cycle with |d0 in GROUP, SUM, DECIDE, SEND or HOLDOFF.
- All status counters wrap at 2^32.
- Config inputs are read live; software changes them only while cfg_enable=0.

## Timing
- Reset: state IDLE; d0, mask, ts, T, cntr, gor, sum all 0; m_axis_tvalid=0; m_axis_tdata=0; all sts_* = 0.
- Reset asserted mid-event aborts it immediately, with no output and no counter update. tvalid drops on the next edge.
- Detection cycle C is the IDLE cycle with |d0. tvalid first high in cycle C+W+4, with ts = T value in cycle C.
- tdata is constant while tvalid=1. tvalid never drops without a handshake.
- Minimum spacing between detection cycles is W+H+6 with tready held high.
- A hit in the same cycle as the HOLDOFF→IDLE transition is not detected but is counted in sts_busy_hits. The next cycle's hit is detected.

## Structure
- Package axis_detector_trigger_pkg holds:
  - the state encoding (IDLE, ACCUM, GROUP, SUM, DECIDE, SEND, HOLDOFF; 3 bits)
  - the SUM_WIDTH derivation function
- Sub-module det_group_reduce (parameters DET_WIDTH, GROUP_COUNT) holds the combinational group-OR and popcount. The top level registers its outputs in GROUP and SUM.

## Test plan
All scenarios use DET_WIDTH=64, GROUP_COUNT=4, tready=1 unless stated.
- W=0, H=0, thresh=2: det_data=0x0001_0000_0000_0001 for one cycle. Response: one beat with mask=0x0001_0000_0000_0001, tvalid in C+4, ts=T at C, sts_accepted=1.
- W=3, thresh=3: bit 0 at C, bit 20 at C+2, bit 40 at C+3, bit 60 at C+5. Response: mask=0x0000_0100_0010_0001 (bit 60 excluded), tvalid in C+7, accepted.
- thresh=3, hit only in group 0 (det_data=0xFFFF) → no beat, sts_rejected=1. thresh=0 with same stimulus → beat emitted.
- Backpressure: tready=0 for 10 cycles after tvalid, with hits injected meanwhile. Response: tdata stable, sts_busy_hits=10, no second event until handshake + H+1.
- H=5: continuous hits. Response: consecutive detection cycles exactly W+H+6 apart. cfg_enable=0 → no new events, but the in-flight event is delivered.
- Reset asserted in ACCUM and in SEND. Response: next cycle tvalid=0, all outputs zero, and a fresh event afterwards behaves as in scenario 1.
